// File: rtl/elastic_pipeline_buffer_if.sv
// Valid/ready beat channel between pipeline stages.
// The master drives data/valid and the slave drives ready.
interface elastic_pipeline_buffer_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/elastic_pipeline_buffer.sv
// DEPTH-entry elastic buffer between two pipeline stages, with stall/flush control and occupancy status.
// Optional almost-full status output is enabled by defining PIPELINE_BUFFER_ALMOST_FULL_EN.
module elastic_pipeline_buffer #(
   parameter int DATA_WIDTH      = 32,
   parameter int DEPTH           = 2,
   parameter int CNT_WIDTH       = $clog2(DEPTH + 1),
   parameter int ALMOST_FULL_THR = DEPTH - 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   elastic_pipeline_buffer_if.slave  s_data,
   elastic_pipeline_buffer_if.master m_data,
   input  logic                      s_ctrl_stall,
   input  logic                      s_ctrl_flush,
   output logic                      s_status_busy,
   output logic [CNT_WIDTH-1:0]      s_status_count
`ifdef PIPELINE_BUFFER_ALMOST_FULL_EN
   ,
   output logic                      s_status_almost_full
`endif
);
   localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_WIDTH-1:0]  r_wr_ptr;
   logic [PTR_WIDTH-1:0]  r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_count;

   logic w_ready;
   logic w_valid;
   logic w_push;
   logic w_pop;

   function automatic logic [PTR_WIDTH-1:0] f_next_ptr(input logic [PTR_WIDTH-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + PTR_WIDTH'(1);
   endfunction

   // Ready ignores the downstream side so the upstream ready path stays registered-state only.
   assign w_ready = ~rst_i & ~s_ctrl_stall & ~s_ctrl_flush & (r_count < FULL_CNT);
   assign w_valid = (r_count != '0) & ~s_ctrl_stall & ~s_ctrl_flush;
   assign w_push  = s_data.valid & w_ready;
   assign w_pop   = w_valid & m_data.ready;

   assign s_data.ready   = w_ready;
   assign m_data.valid   = w_valid;
   assign m_data.data    = w_valid ? r_mem[r_rd_ptr] : '0;
   assign s_status_busy  = (r_count != '0);
   assign s_status_count = r_count;

`ifdef PIPELINE_BUFFER_ALMOST_FULL_EN
   assign s_status_almost_full = (int'(r_count) >= ALMOST_FULL_THR);
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (s_ctrl_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_WIDTH'(1);
            2'b01:   r_count <= r_count - CNT_WIDTH'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= s_data.data;
   end
endmodule

// File: tb/tb_elastic_pipeline_buffer.sv
// Scoreboard bench for elastic_pipeline_buffer at DEPTH 2, 3 and 4.
// Instance k has DEPTH k+2; define PIPELINE_BUFFER_ALMOST_FULL_EN to also check almost_full.
module tb_elastic_pipeline_buffer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       in_valid  [3];
   logic [7:0] in_data   [3];
   logic       out_ready [3];
   logic       stall     [3];
   logic       flush     [3];
   logic       rst       [3];

   logic [2:0]      ready_o;
   logic [2:0]      valid_o;
   logic [2:0]      busy_o;
   logic [2:0]      af_o;
   logic [2:0][7:0] data_o;
   logic [2:0][2:0] cnt_o;

   int         m_cnt = 0;
   logic [7:0] sb [$];
   logic       acc;
   logic       popd;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int D  = k + 2;
      localparam int CW = $clog2(D + 1);
      logic [CW-1:0] cnt;
      logic          af;
      elastic_pipeline_buffer_if #(.DATA_WIDTH(8)) s_if ();
      elastic_pipeline_buffer_if #(.DATA_WIDTH(8)) m_if ();

      assign s_if.data   = in_data[k];
      assign s_if.valid  = in_valid[k];
      assign m_if.ready  = out_ready[k];
      assign ready_o[k]  = s_if.ready;
      assign valid_o[k]  = m_if.valid;
      assign data_o[k]   = m_if.data;
      assign cnt_o[k]    = 3'(cnt);

      elastic_pipeline_buffer #(.DATA_WIDTH(8), .DEPTH(D)) dut (
         .clk_i          (clk),
         .rst_i          (rst[k]),
         .s_data         (s_if),
         .m_data         (m_if),
         .s_ctrl_stall   (stall[k]),
         .s_ctrl_flush   (flush[k]),
         .s_status_busy  (busy_o[k]),
         .s_status_count (cnt)
`ifdef PIPELINE_BUFFER_ALMOST_FULL_EN
         ,
         .s_status_almost_full (af)
`endif
      );
`ifdef PIPELINE_BUFFER_ALMOST_FULL_EN
      assign af_o[k] = af;
`else
      assign af = 1'b0;
      assign af_o[k] = af;
`endif
   end

   // One cycle on instance k: drive at negedge, compare against the model, then advance the model.
   task automatic step(input int k, input logic v, input logic [7:0] d, input logic mr,
                       input logic st, input logic fl, output logic o_acc, output logic o_pop);
      logic       exp_ready;
      logic       exp_valid;
      logic [7:0] exp_data;
      @(negedge clk);
      in_valid[k] = v; in_data[k] = d; out_ready[k] = mr; stall[k] = st; flush[k] = fl;
      #1;
      exp_ready = !st && !fl && (m_cnt < k + 2);
      exp_valid = (m_cnt != 0) && !st && !fl;
      exp_data  = exp_valid ? sb[0] : 8'h00;
      checks++;
      if (ready_o[k] !== exp_ready) begin
         errors++; $display("FAIL dut%0d s_data_ready: got %0b want %0b", k, ready_o[k], exp_ready);
      end
      checks++;
      if (valid_o[k] !== exp_valid) begin
         errors++; $display("FAIL dut%0d m_data_valid: got %0b want %0b", k, valid_o[k], exp_valid);
      end
      checks++;
      if (data_o[k] !== exp_data) begin
         errors++; $display("FAIL dut%0d m_data_data: got %02h want %02h", k, data_o[k], exp_data);
      end
      checks++;
      if (cnt_o[k] !== 3'(m_cnt)) begin
         errors++; $display("FAIL dut%0d s_status_count: got %0d want %0d", k, cnt_o[k], m_cnt);
      end
      checks++;
      if (busy_o[k] !== (m_cnt != 0)) begin
         errors++; $display("FAIL dut%0d s_status_busy: got %0b want %0b", k, busy_o[k], m_cnt != 0);
      end
`ifdef PIPELINE_BUFFER_ALMOST_FULL_EN
      checks++;
      if (af_o[k] !== (m_cnt >= k + 1)) begin
         errors++; $display("FAIL dut%0d almost_full: got %0b want %0b", k, af_o[k], m_cnt >= k + 1);
      end
`endif
      o_acc = exp_ready && v;
      o_pop = exp_valid && mr;
      if (fl) begin
         sb.delete();
         m_cnt = 0;
      end else begin
         if (o_pop) begin void'(sb.pop_front()); m_cnt--; end
         if (o_acc) begin sb.push_back(d); m_cnt++; end
      end
   endtask

   task automatic drain(input int k);
      int cyc = 0;
      while (m_cnt != 0 && cyc < 20) begin
         step(k, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc, popd);
         cyc++;
      end
      checks++;
      if (m_cnt != 0) begin
         errors++; $display("FAIL dut%0d drain timeout: got %0d left want 0", k, m_cnt);
      end
      step(k, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc, popd);
   endtask

   task automatic test_reset();
      #12;
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({ready_o[k], valid_o[k], busy_o[k], af_o[k], data_o[k], cnt_o[k]} !== 15'd0) begin
            errors++;
            $display("FAIL reset dut%0d outputs: got rdy=%0b vld=%0b busy=%0b af=%0b data=%02h cnt=%0d want all 0",
                     k, ready_o[k], valid_o[k], busy_o[k], af_o[k], data_o[k], cnt_o[k]);
         end
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         step(0, 1'b1, 8'(8'hA0 + i), 1'b1, 1'b0, 1'b0, acc, popd);
         checks++;
         if (cnt_o[0] > 3'd1) begin
            errors++; $display("FAIL b2b count bound: got %0d want <=1", cnt_o[0]);
         end
      end
      drain(0);
   endtask

   task automatic test_backpressure();
      int idx = 0;
      int cyc = 0;
      while ((idx < 6 || m_cnt != 0) && cyc < 40) begin
         step(2, idx < 6, 8'(8'h10 + idx), cyc >= 8, 1'b0, 1'b0, acc, popd);
         if (cyc == 6) begin
            checks++;
            if (cnt_o[2] !== 3'd4 || ready_o[2] !== 1'b0) begin
               errors++; $display("FAIL backpressure full: got cnt=%0d rdy=%0b want cnt=4 rdy=0", cnt_o[2], ready_o[2]);
            end
         end
         if (acc) idx++;
         cyc++;
      end
      checks++;
      if (idx != 6 || m_cnt != 0) begin
         errors++; $display("FAIL backpressure timeout: got accepted=%0d left=%0d want 6 and 0", idx, m_cnt);
      end
      step(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc, popd);
   endtask

   task automatic test_wrap();
      int idx = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 1'b1, 8'(8'h30 + idx), (i % 2) == 0, 1'b0, 1'b0, acc, popd);
         if (acc) idx++;
      end
      drain(1);
      checks++;
      if (cnt_o[1] !== 3'd0 || valid_o[1] !== 1'b0) begin
         errors++; $display("FAIL wrap empty: got cnt=%0d vld=%0b want 0 0", cnt_o[1], valid_o[1]);
      end
   endtask

   task automatic test_stall();
      step(2, 1'b1, 8'h50, 1'b0, 1'b0, 1'b0, acc, popd);
      step(2, 1'b1, 8'h51, 1'b0, 1'b0, 1'b0, acc, popd);
      for (int i = 0; i < 3; i++) begin
         step(2, 1'b1, 8'h5F, 1'b1, 1'b1, 1'b0, acc, popd);
         checks++;
         if (cnt_o[2] !== 3'd2) begin
            errors++; $display("FAIL stall hold count: got %0d want 2", cnt_o[2]);
         end
      end
      step(2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, acc, popd);
      checks++;
      if (data_o[2] !== 8'h50 || valid_o[2] !== 1'b1) begin
         errors++; $display("FAIL stall release head: got %02h vld=%0b want 50 1", data_o[2], valid_o[2]);
      end
      drain(2);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) step(2, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0, acc, popd);
      step(2, 1'b1, 8'h6F, 1'b1, 1'b1, 1'b1, acc, popd);
      step(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc, popd);
      checks++;
      if (cnt_o[2] !== 3'd0 || busy_o[2] !== 1'b0 || data_o[2] !== 8'h00) begin
         errors++; $display("FAIL flush clears: got cnt=%0d busy=%0b data=%02h want 0 0 00", cnt_o[2], busy_o[2], data_o[2]);
      end
   endtask

   task automatic test_async_reset();
      step(0, 1'b1, 8'h70, 1'b0, 1'b0, 1'b0, acc, popd);
      step(0, 1'b1, 8'h71, 1'b0, 1'b0, 1'b0, acc, popd);
      @(posedge clk);
      #1;
      checks++;
      if (cnt_o[0] !== 3'd2) begin
         errors++; $display("FAIL async reset setup count: got %0d want 2", cnt_o[0]);
      end
      out_ready[0] = 1'b1;
      #1;
      rst[0] = 1'b1;
      #1;
      checks++;
      if ({ready_o[0], valid_o[0], busy_o[0], af_o[0], data_o[0], cnt_o[0]} !== 15'd0) begin
         errors++;
         $display("FAIL async reset outputs: got rdy=%0b vld=%0b busy=%0b af=%0b data=%02h cnt=%0d want all 0",
                  ready_o[0], valid_o[0], busy_o[0], af_o[0], data_o[0], cnt_o[0]);
      end
      in_valid[0] = 1'b0; out_ready[0] = 1'b0;
      sb.delete();
      m_cnt = 0;
      @(negedge clk);
      rst[0] = 1'b0;
      step(0, 1'b1, 8'h7A, 1'b0, 1'b0, 1'b0, acc, popd);
      drain(0);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; in_valid[k] = 1'b0; in_data[k] = 8'h00;
         out_ready[k] = 1'b0; stall[k] = 1'b0; flush[k] = 1'b0;
      end
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_stall();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/elastic_pipeline_buffer.md
Name: elastic_pipeline_buffer

Overview:
Parametrised successor of the single-slot pipeline register: a DEPTH-entry elastic buffer between two pipeline stages, using the valid/ready data ports, stall/flush control ports and busy status port.
- Full throughput (one beat per cycle) with a registered ready path.
- Absorbs up to DEPTH beats of downstream backpressure.
- Reports its occupancy to control units.
- Sits between functional-unit stages in the protection-table lookup pipeline.

Parameters:
DATA_WIDTH, 32, width of the data payload in bits (>=1)
DEPTH, 2, number of storage slots (>=1; need not be a power of 2; >=2 required for full throughput)
CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width (derived; do not override)
ALMOST_FULL_THR, DEPTH-1, occupancy at or above which almost_full asserts (used only with the optional feature)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-high reset
s_data_data  in  DATA_WIDTH  upstream payload
s_data_valid  in  1  upstream beat valid
s_data_ready  out  1  buffer can accept a beat this cycle
m_data_data  out  DATA_WIDTH  head-of-buffer payload
m_data_valid  out  1  head beat valid
m_data_ready  in  1  downstream accepts head beat
s_ctrl_stall  in  1  external stall; freezes the buffer
s_ctrl_flush  in  1  synchronous flush; discards all contents
s_status_busy  out  1  buffer holds at least one beat
s_status_count  out  CNT_WIDTH  current occupancy, 0..DEPTH

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs while in reset: s_data_ready=0, m_data_valid=0, m_data_data='0, s_status_busy=0, s_status_count=0.
  - Storage array is not reset.
- Push: s_data_valid & s_data_ready.
  - Writes mem[wr_ptr].
  - wr_ptr wraps from DEPTH-1 to 0.
- Pop: m_data_valid & m_data_ready.
  - rd_ptr wraps from DEPTH-1 to 0.
- Latency: a beat pushed at edge N is presented on m_data_* from cycle N+1. There is no combinational input-to-output bypass.
- s_data_ready = ~rst_i & ~s_ctrl_stall & ~s_ctrl_flush & (count < DEPTH).
  - Ready does not depend on m_data_ready: no push when full, even if a pop occurs in the same cycle.
- m_data_valid = (count != 0) & ~s_ctrl_stall & ~s_ctrl_flush.
- m_data_data = mem[rd_ptr] when m_data_valid, else '0.
- Count update (not stalled, not flushed):
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance
- Stall (s_ctrl_stall=1, flush=0): no push, no pop, all state holds. Status outputs still reflect the held count.
- Flush (s_ctrl_flush=1): at the next edge, pointers and count go to 0.
  - No push or pop occurs in the flush cycle.
  - Flush has priority over stall.
- Full (count==DEPTH): s_data_ready=0; contents are held until a pop.
- Empty (count==0): m_data_valid=0 and m_data_data='0.
- s_status_busy = (count != 0); s_status_count = count. Both are registered-state derived and unaffected by stall or flush inputs in the current cycle.
- DEPTH=1: a legal single-slot register. Ready is low while occupied, so maximum throughput is one beat every 2 cycles.
- Reset mid-transfer: all beats are lost. Outputs go to reset values immediately, asynchronously.

Optional Feature:
Macro PIPELINE_BUFFER_ALMOST_FULL_EN.
- Defined: adds output port s_status_almost_full (1 bit) = (count >= ALMOST_FULL_THR). It is 0 in reset and after a flush, and is intended for upstream throttling.
- Undefined: the port and its logic are absent, and ALMOST_FULL_THR is ignored.

Test Plan:
- DEPTH=2, m_data_ready=1, push 0xA0..0xA7 back-to-back for 8 cycles -> m_data_valid high cycles 1..8, data 0xA0..0xA7 in order, s_data_ready never drops, count stays <=1.
- DEPTH=4, m_data_ready=0, push 6 beats 0x10..0x15 -> 0x10..0x13 accepted, s_data_ready=0 from the cycle count=4, s_status_count=4. Raise m_data_ready -> 0x10..0x13 out, then 0x14,0x15 accepted and out in order.
- DEPTH=3, non-power-of-2 wrap: 10 push/pop cycles with m_data_ready toggling 1,0,1,0 -> pointers wrap 2->0, output order equals input order, no duplicate or lost beat.
- Count=2, assert s_ctrl_stall 3 cycles with s_data_valid=1 and m_data_ready=1 -> s_data_ready=0, m_data_valid=0, count holds 2. Release -> head beat delivered next cycle.
- Count=3, assert s_ctrl_stall and s_ctrl_flush together for 1 cycle with s_data_valid=1 -> no push, next cycle count=0, s_status_busy=0, m_data_data='0.
- Assert rst_i asynchronously mid-burst with count=2 -> outputs reset without waiting for a clock edge. With PIPELINE_BUFFER_ALMOST_FULL_EN, DEPTH=4, THR=3: almost_full rises exactly when count reaches 3.
